// File: rtl/local_maxima_pkg.sv
// Shared types and default constants for the streaming local-maximum detector.
package local_maxima_pkg;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_N_SAMPLES = 36;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {GT, EQ, LT} cmp_t;
endpackage

// File: rtl/lmax_cmp.sv
// Unsigned three-way compare of the newest sample against the previous one.
module lmax_cmp
  import local_maxima_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] prev,
  output cmp_t              res
);

  always_comb begin
    if (x > prev)       res = GT;
    else if (x == prev) res = EQ;
    else                res = LT;
  end

endmodule

// File: rtl/local_maxima_cpu_v2.sv
// Streaming local-maximum detector: pulses out when a rise is followed by a fall.
// Optional LMAX_COUNT_EN adds a saturating 8-bit max_count output.
//
// state | meaning
// IDLE  | no sample captured yet in this run
// RUN   | comparing each accepted sample against the previous one
// DONE  | N_SAMPLES captured; input ignored until reset
module local_maxima_cpu_v2
  import local_maxima_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int N_SAMPLES = DEF_N_SAMPLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] in,
  output logic              out,
  output logic              finish
`ifdef LMAX_COUNT_EN
  ,
  output logic [7:0]        max_count
`endif
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);

  state_t            state;
  state_t            state_next;
  cmp_t              cmp_res;
  logic [DATA_W-1:0] prev;
  logic [CNT_W-1:0]  cnt;
  logic              rising;
  logic              rising_next;
  logic              out_next;
  logic              finish_next;
  logic              accept;
  logic              last;

  lmax_cmp #(.DATA_W(DATA_W)) u_cmp (
    .x    (in),
    .prev (prev),
    .res  (cmp_res)
  );

  assign accept = en && (state != DONE);
  // cnt still holds the count before this sample, so N_SAMPLES-1 means this one is the last
  assign last   = (cnt == CNT_W'(N_SAMPLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (en && last) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_next    = 1'b0;
    rising_next = rising;
    finish_next = (state_next == DONE);
    if (state == IDLE && en) begin
      rising_next = 1'b0;
    end else if (state == RUN && en) begin
      case (cmp_res)
        GT:      rising_next = 1'b1;
        LT: begin
          out_next    = rising;
          rising_next = 1'b0;
        end
        default: rising_next = rising;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out    <= 1'b0;
      finish <= 1'b0;
      rising <= 1'b0;
      prev   <= '0;
      cnt    <= '0;
    end else begin
      out    <= out_next;
      finish <= finish_next;
      rising <= rising_next;
      if (accept) begin
        prev <= in;
        cnt  <= (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
      end
    end
  end

`ifdef LMAX_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            max_count <= '0;
    else if (out_next && max_count != 8'hFF) max_count <= max_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_local_maxima_cpu_v2.sv
// Directed self-checking bench for local_maxima_cpu_v2 with hand-computed expectations.
module tb_local_maxima_cpu_v2;
  import local_maxima_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] smp;
  logic       pulse;
  logic       finish;
`ifdef LMAX_COUNT_EN
  logic [7:0] max_count;
`endif

  int n_checks;
  int n_pass;

  local_maxima_cpu_v2 dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .in     (smp),
    .out    (pulse),
    .finish (finish)
`ifdef LMAX_COUNT_EN
    ,
    .max_count (max_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send(input logic e, input logic [7:0] x);
    @(negedge clk);
    en  = e;
    smp = x;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    smp = 8'($urandom_range(0, 255));
    @(negedge clk);
    smp = 8'($urandom_range(0, 255));
    @(negedge clk);
    check("rst_out", {31'd0, pulse}, 32'd0);
    check("rst_finish", {31'd0, finish}, 32'd0);
`ifdef LMAX_COUNT_EN
    check("rst_max_count", {24'd0, max_count}, 32'd0);
`endif
    rst = 1'b1;
    en  = 1'b0;
  endtask

  int full_seq [36] = '{2,3,1,4,0,0,1,4,4,3,2,2,3,2,0,1,4,4,4,4,1,5,0,3,1,2,0,4,2,0,4,3,2,1,3,4};
  int peak_idx [10] = '{2,4,9,13,20,22,24,26,28,31};
  int plat_a [5] = '{1,4,4,4,1};
  int plat_b [4] = '{5,2,2,3};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    en  = 1'b0;
    smp = '0;

    do_reset();
    send(1'b1, 8'd2); check("basic_s0", {31'd0, pulse}, 32'd0);
    send(1'b1, 8'd3); check("basic_s1", {31'd0, pulse}, 32'd0);
    send(1'b1, 8'd1); check("basic_peak", {31'd0, pulse}, 32'd1);
    send(1'b0, 8'd0); check("basic_one_cycle", {31'd0, pulse}, 32'd0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 8'(plat_a[i]));
      check($sformatf("plateau_peak_%0d", i), {31'd0, pulse}, (i == 4) ? 32'd1 : 32'd0);
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'(plat_b[i]));
      check($sformatf("plateau_fall_%0d", i), {31'd0, pulse}, 32'd0);
    end

    do_reset();
    send(1'b1, 8'd1);
    send(1'b1, 8'd5); check("gap_rise", {31'd0, pulse}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 8'd0);
      check($sformatf("gap_idle_%0d", i), {31'd0, pulse}, 32'd0);
    end
    send(1'b1, 8'd2); check("gap_peak", {31'd0, pulse}, 32'd1);
    send(1'b0, 8'd0); check("gap_after", {31'd0, pulse}, 32'd0);

    do_reset();
    begin
      int pulses;
      int k;
      pulses = 0;
      k = 0;
      for (int i = 0; i < 36; i++) begin
        logic exp_p;
        exp_p = 1'b0;
        if (k < 10 && peak_idx[k] == i) begin
          exp_p = 1'b1;
          k++;
        end
        send(1'b1, 8'(full_seq[i]));
        if (pulse) pulses++;
        check($sformatf("full_out_%0d", i), {31'd0, pulse}, {31'd0, exp_p});
        if (i == 34) check("full_finish_early", {31'd0, finish}, 32'd0);
      end
      check("full_pulse_count", pulses, 32'd10);
      check("full_finish", {31'd0, finish}, 32'd1);
`ifdef LMAX_COUNT_EN
      check("full_max_count", {24'd0, max_count}, 32'd10);
`endif
    end

    send(1'b1, 8'd0); check("done_out_0", {31'd0, pulse}, 32'd0);
    send(1'b1, 8'd9); check("done_out_1", {31'd0, pulse}, 32'd0);
    send(1'b1, 8'd0); check("done_out_2", {31'd0, pulse}, 32'd0);
    check("done_finish", {31'd0, finish}, 32'd1);

    // Drop reset mid-cycle, well away from any clock edge.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_finish", {31'd0, finish}, 32'd0);
    check("async_out", {31'd0, pulse}, 32'd0);
`ifdef LMAX_COUNT_EN
    check("async_max_count", {24'd0, max_count}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/local_maxima_cpu_v2.md
Name: local_maxima_cpu_v2

Overview:
Streaming local-maximum detector. It accepts one unsigned sample per enabled clock and pulses `out` when the most recent non-flat transition turns from rising to falling, i.e. a peak or plateau-peak is confirmed. After a fixed number of samples it raises `finish` and ignores further input. It sits as a small control/compute block fed by an upstream sample source.

Parameters:
- DATA_W, 8, sample width in bits (unsigned).
- N_SAMPLES, 36, number of samples per run; `finish` asserts after the N_SAMPLES-th sample is captured. Minimum is 3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sample-valid; `in` is captured on each rising edge where en=1 and the block is not finished.
- in  in  DATA_W  input sample.
- out  out  1  registered one-cycle pulse: local maximum confirmed.
- finish  out  1  registered, sticky: run complete.

Behaviour:
- Interface decision, fixed: one clock; reset is asynchronous and active-low; clock port is `clk`, reset port is `rst`.
- Reset (rst=0, asynchronous):
  - out=0, finish=0, sample counter=0, prev=0, rising=0.
  - FSM goes to IDLE.
  - A reset mid-run discards all history.
- FSM states:
  - IDLE: no sample captured yet. An accepted sample goes to prev, counter=1, rising=0, next state RUN. out stays 0.
  - RUN: each accepted sample x is compared against prev:
    - x>prev: rising<=1, out<=0.
    - x==prev: rising unchanged, out<=0 (plateau).
    - x<prev: out<=rising, then rising<=0.
    - In all three cases prev<=x and counter increments.
  - Run end: when the accepted sample is number N_SAMPLES, finish<=1 on the same edge and the state goes to DONE. That sample's out decision is still issued in the same cycle.
  - DONE: inputs ignored, out=0, finish held at 1 until reset.
- Latency: `out` is visible in the cycle after the edge that captured the first strictly-lower sample following the peak.
  - A plateau peak produces exactly one pulse, at the drop.
  - A plateau entered by a fall never pulses.
- Endpoints are never maxima:
  - First sample: rising starts at 0.
  - Last sample: no right neighbour, so no pulse for a final rise.
- en=0 in RUN: state frozen, out<=0. A pulse is never held beyond one cycle.
- en is don't-care while rst=0.
- Comparisons are unsigned, DATA_W bits. No arithmetic overflow is possible.
- Counter width is clog2(N_SAMPLES+1). It saturates in DONE and never wraps.

Optional Feature:
- Macro: LMAX_COUNT_EN.
- With the macro defined, an extra output port `max_count` (width 8) is added.
  - It increments, saturating at 255, on every out pulse.
  - It resets to 0 and holds its value in DONE.
- Without the macro, the port and its logic are absent; everything else is identical.

Decomposition:
- Package `local_maxima_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - default constants DATA_W=8 and N_SAMPLES=36;
  - the comparison result enum (GT, EQ, LT).
- One sub-module, `lmax_cmp`, is natural: a combinational compare of x vs prev producing GT/EQ/LT.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random `in` → out=0 and finish=0. Release, then feed 2,3,1 → out pulses once, the cycle after 1 is captured (peak 3).
- Full run with en=1 continuously, N_SAMPLES=36, sequence 2,3,1,4,0,0,1,4,4,3,2,2,3,2,0,1,4,4,4,4,1,5,0,3,1,2,0,4,2,0,4,3,2,1,3,4:
  - exactly 10 out pulses, after samples at indices 2,4,9,13,20,22,24,26,28,31;
  - finish=1 the cycle after sample 36;
  - no pulse for the trailing 4.
- Plateau cases: 1,4,4,4,1 → one pulse, after the final 1. Sequence 5,2,2,3 → no pulse.
- en gaps: feed 1,5 then en=0 for 3 cycles then 2 → out stays 0 during the gap and pulses once after the 2 is captured.
- DONE behaviour: after finish, apply 0,9,0 with en=1 → out stays 0 and finish stays 1. Assert rst=0 → finish=0 immediately, asynchronously.
- With LMAX_COUNT_EN: the full-run sequence gives max_count=10 at finish; max_count returns to 0 on reset.
